game_controller: RTL and testbench
==================================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter NUM_LEVELS, default 3, number of maze levels per game (2..2**LEVEL_BITS).
REQ-002 SHALL have parameter LEVEL_BITS, default 2, width of level output.
REQ-003 SHALL have parameter RESULT_HOLD, default 100, cycles WIN/LOSE is held before returning to IDLE (>=1).
REQ-004 SHALL have port clock  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start_btn  input  1  start button level, synchronous to clock.
REQ-007 SHALL have port pause_btn  input  1  pause/resume button level, synchronous to clock.
REQ-008 SHALL have port goal_reached  input  1  player reached maze exit (level, sampled each cycle).
REQ-009 SHALL have port timer_end  input  1  countdown timer expired.
REQ-010 SHALL have port timer_load  output  1  one-cycle pulse reloading the countdown timer.
REQ-011 SHALL have port timer_run  output  1  countdown timer enable.
REQ-012 SHALL have port player_enable  output  1  player movement allowed.
REQ-013 SHALL have port level  output  LEVEL_BITS  current level, 0-based.
REQ-014 SHALL have port state_out  output  3  state encoding per REQ-016.
REQ-015 SHALL have ports win, lose  output  1 each  result flags.

Function
REQ-016 SHALL implement Moore FSM: IDLE=0, LOAD=1, PLAY=2, PAUSE=3, LEVEL_UP=4, WIN=5, LOSE=6; 7 unused -> IDLE next cycle.
REQ-017 SHALL rising-edge detect start_btn and pause_btn via registered previous value; edge = btn & ~prev.
REQ-018 SHALL derive all outputs from registered state/level only; outputs valid in the first cycle of the new state.
REQ-019 IDLE: start edge -> LOAD, level <= 0; all else ignored.
REQ-020 LOAD: exactly one cycle, timer_load=1, -> PLAY.
REQ-021 PLAY: timer_run=1, player_enable=1; priority goal_reached > timer_end > pause edge.
REQ-022 PLAY + goal_reached: level==NUM_LEVELS-1 -> WIN, else -> LEVEL_UP.
REQ-023 PLAY + timer_end (no goal) -> LOSE.
REQ-024 PLAY + pause edge (no goal, no timer_end) -> PAUSE.
REQ-025 PAUSE: timer_run=0, player_enable=0; pause edge -> PLAY; goal_reached, timer_end, start edge ignored.
REQ-026 LEVEL_UP: one cycle, level <= level+1 (no wrap, bounded by REQ-022), -> LOAD.
REQ-027 WIN: win=1; LOSE: lose=1; both hold level, timer_run=0, player_enable=0.
REQ-028 WIN/LOSE: hold counter (width clog2(RESULT_HOLD+1)) cleared on entry; after RESULT_HOLD cycles in state -> IDLE; buttons ignored.
REQ-029 Latency: start edge at cycle N -> LOAD at N+1 (timer_load high), PLAY at N+2.
REQ-030 timer_load SHALL be high only in LOAD; never two consecutive cycles.

Reset
REQ-031 reset low at a rising clock edge SHALL force state IDLE, level 0, hold counter 0, all outputs 0, from any state including mid-game.
REQ-032 Edge-detect registers SHALL reset to 1, so a button held through reset release produces no edge.
REQ-033 Reset SHALL take priority over every other input on the same edge.

Verification
REQ-034 Reset low 2 cycles, start_btn held high across release -> state_out=0, no LOAD until start released and pressed again.
REQ-035 Start pulse cycle N -> timer_load=1 only at N+1, state_out=2 and timer_run=1 at N+2.
REQ-036 NUM_LEVELS=3, goal_reached pulses in PLAY three times -> level 0->1->2, two extra LOAD pulses, then WIN, win=1 for 100 cycles, then IDLE.
REQ-037 PLAY, goal_reached and timer_end same cycle at level 0 -> LEVEL_UP, not LOSE; timer_end alone later -> LOSE, lose=1.
REQ-038 PLAY, pause edge -> PAUSE, timer_run=0; timer_end and goal_reached asserted in PAUSE -> no change; pause edge -> PLAY.
REQ-039 Reset low during PAUSE at level 1 -> next cycle state_out=0, level=0, all outputs 0.

Source files
------------

// File: rtl/game_controller.sv
// -----------------------------------------------------------------------------
// game_controller
//
// Sequences a maze game. A game is started from IDLE, and each level runs as
// LOAD (reload the countdown timer) followed by PLAY. In PLAY the player can
// reach the goal, run out of time, or pause. Reaching the goal on the last
// level wins the game. The WIN or LOSE result is held for RESULT_HOLD cycles,
// after which the controller returns to IDLE.
//
// Parameters
//   NUM_LEVELS  : levels per game (2 .. 2**LEVEL_BITS)
//   LEVEL_BITS  : width of the level output
//   RESULT_HOLD : cycles that WIN/LOSE is held before returning to IDLE (>= 1)
//
// Ports
//   clock         : in  system clock; all logic runs on its rising edge
//   reset         : in  synchronous, active-low reset
//   start_btn     : in  start button level (rising edge starts a game)
//   pause_btn     : in  pause/resume button level (rising edge toggles pause)
//   goal_reached  : in  player is at the maze exit
//   timer_end     : in  countdown timer has expired
//   timer_load    : out one-cycle pulse in LOAD that reloads the timer
//   timer_run     : out timer enable (PLAY only)
//   player_enable : out player movement allowed (PLAY only)
//   level         : out current level, 0-based
//   state_out     : out FSM state (IDLE=0 LOAD=1 PLAY=2 PAUSE=3 LEVEL_UP=4
//                       WIN=5 LOSE=6)
//   win, lose     : out result flags, high throughout WIN / LOSE
//
// There is no valid/ready handshake on this block. Every output is a pure
// function of registered state, so all outputs are valid from the first cycle
// of a new state and are stable for the whole cycle.
// -----------------------------------------------------------------------------
module game_controller #(
  parameter int NUM_LEVELS  = 3,
  parameter int LEVEL_BITS  = 2,
  parameter int RESULT_HOLD = 100
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_btn,
  input  logic                  pause_btn,
  input  logic                  goal_reached,
  input  logic                  timer_end,
  output logic                  timer_load,
  output logic                  timer_run,
  output logic                  player_enable,
  output logic [LEVEL_BITS-1:0] level,
  output logic [2:0]            state_out,
  output logic                  win,
  output logic                  lose
);

  localparam int HOLD_W = $clog2(RESULT_HOLD + 1);
  localparam logic [HOLD_W-1:0]     HOLD_LAST  = HOLD_W'(RESULT_HOLD - 1);
  localparam logic [LEVEL_BITS-1:0] LAST_LEVEL = LEVEL_BITS'(NUM_LEVELS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_PLAY     = 3'd2,
    S_PAUSE    = 3'd3,
    S_LEVEL_UP = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_t;

  state_t                  state_q;
  state_t                  next_state;
  logic [LEVEL_BITS-1:0]   level_q;
  logic [HOLD_W-1:0]       hold_cnt;
  logic                    start_prev;
  logic                    pause_prev;

  // The previous-value registers reset to 1, so a button that is already
  // held when reset is released does not count as a press.
  logic start_edge;
  logic pause_edge;
  assign start_edge = start_btn & ~start_prev;
  assign pause_edge = pause_btn & ~pause_prev;

  // ---------------------------------------------------------------------------
  // State register, plus level, hold counter and button history
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      level_q    <= '0;
      hold_cnt   <= '0;
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
    end else begin
      state_q    <= next_state;
      start_prev <= start_btn;
      pause_prev <= pause_btn;

      // A new game restarts at level 0. LEVEL_UP is only reachable below
      // the last level, so the increment cannot wrap.
      if (state_q == S_IDLE && next_state == S_LOAD) begin
        level_q <= '0;
      end else if (state_q == S_LEVEL_UP) begin
        level_q <= level_q + LEVEL_BITS'(1);
      end

      // Counts the cycles spent in WIN/LOSE. Any state change clears it,
      // so it starts at 0 in the entry cycle.
      if (next_state != state_q) begin
        hold_cnt <= '0;
      end else if (state_q == S_WIN || state_q == S_LOSE) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge) next_state = S_LOAD;
      end
      S_LOAD: begin
        next_state = S_PLAY;
      end
      S_PLAY: begin
        // Goal takes priority over timeout, and timeout over pause.
        if (goal_reached) begin
          next_state = (level_q == LAST_LEVEL) ? S_WIN : S_LEVEL_UP;
        end else if (timer_end) begin
          next_state = S_LOSE;
        end else if (pause_edge) begin
          next_state = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_edge) next_state = S_PLAY;
      end
      S_LEVEL_UP: begin
        next_state = S_LOAD;
      end
      S_WIN, S_LOSE: begin
        // hold_cnt == HOLD_LAST marks the RESULT_HOLD-th cycle in this state.
        if (hold_cnt == HOLD_LAST) next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    timer_load    = 1'b0;
    timer_run     = 1'b0;
    player_enable = 1'b0;
    win           = 1'b0;
    lose          = 1'b0;
    case (state_q)
      S_LOAD: timer_load = 1'b1;
      S_PLAY: begin
        timer_run     = 1'b1;
        player_enable = 1'b1;
      end
      S_WIN:  win  = 1'b1;
      S_LOSE: lose = 1'b1;
      default: ;
    endcase
  end

  assign level     = level_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_game_controller.sv
// -----------------------------------------------------------------------------
// tb_game_controller
//
// Drives directed game scenarios followed by randomized button, goal and timer
// activity. A reference model of the game rules predicts the outputs for every
// cycle and pushes them into exp_q. A monitor compares the DUT outputs against
// the queue on each falling edge.
// -----------------------------------------------------------------------------
module tb_game_controller;

  localparam int NUM_LEVELS  = 3;
  localparam int LEVEL_BITS  = 2;
  localparam int RESULT_HOLD = 100;
  localparam int W           = 3 + LEVEL_BITS + 5;

  // Game phases of the reference model. These are named in game terms; the
  // numeric values are the codes the state output is required to show.
  localparam int G_IDLE = 0, G_LOAD = 1, G_PLAY = 2, G_PAUSE = 3,
                 G_LEVEL_UP = 4, G_WIN = 5, G_LOSE = 6;

  // ---------------------------------------------------------------------------
  // Clock and DUT
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start_btn = 1'b0;
  logic pause_btn = 1'b0;
  logic goal_reached = 1'b0;
  logic timer_end = 1'b0;
  logic timer_load, timer_run, player_enable, win, lose;
  logic [LEVEL_BITS-1:0] level;
  logic [2:0] state_out;

  always #5 clock = ~clock;

  game_controller #(
    .NUM_LEVELS (NUM_LEVELS),
    .LEVEL_BITS (LEVEL_BITS),
    .RESULT_HOLD(RESULT_HOLD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start_btn    (start_btn),
    .pause_btn    (pause_btn),
    .goal_reached (goal_reached),
    .timer_end    (timer_end),
    .timer_load   (timer_load),
    .timer_run    (timer_run),
    .player_enable(player_enable),
    .level        (level),
    .state_out    (state_out),
    .win          (win),
    .lose         (lose)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int m_phase      = G_IDLE;
  int m_level      = 0;
  int m_remaining  = 0;   // result cycles still to show, counting down
  bit m_start_held = 1'b1;
  bit m_pause_held = 1'b1;

  task automatic model_step(input logic r, input logic s, input logic p,
                            input logic g, input logic t);
    bit start_press;
    bit pause_press;
    if (!r) begin
      m_phase      = G_IDLE;
      m_level      = 0;
      m_remaining  = 0;
      m_start_held = 1'b1;
      m_pause_held = 1'b1;
      return;
    end
    start_press  = s && !m_start_held;
    pause_press  = p && !m_pause_held;
    m_start_held = s;
    m_pause_held = p;
    if (m_phase == G_IDLE) begin
      if (start_press) begin
        m_phase = G_LOAD;
        m_level = 0;
      end
    end else if (m_phase == G_LOAD) begin
      m_phase = G_PLAY;
    end else if (m_phase == G_PLAY) begin
      if (g) begin
        if (m_level == NUM_LEVELS - 1) begin
          m_phase     = G_WIN;
          m_remaining = RESULT_HOLD;
        end else begin
          m_phase = G_LEVEL_UP;
        end
      end else if (t) begin
        m_phase     = G_LOSE;
        m_remaining = RESULT_HOLD;
      end else if (pause_press) begin
        m_phase = G_PAUSE;
      end
    end else if (m_phase == G_PAUSE) begin
      if (pause_press) m_phase = G_PLAY;
    end else if (m_phase == G_LEVEL_UP) begin
      m_level = m_level + 1;
      m_phase = G_LOAD;
    end else begin
      m_remaining = m_remaining - 1;
      if (m_remaining == 0) m_phase = G_IDLE;
    end
  endtask

  function automatic logic [W-1:0] model_outs();
    logic [2:0]            st;
    logic [LEVEL_BITS-1:0] lv;
    st = 3'(m_phase);
    lv = LEVEL_BITS'(m_level);
    return {st, lv,
            (m_phase == G_LOAD), (m_phase == G_PLAY), (m_phase == G_PLAY),
            (m_phase == G_WIN), (m_phase == G_LOSE)};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic prev_load = 1'b0;

  always @(negedge clock) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {state_out, level, timer_load, timer_run, player_enable, win, lose};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL outs t=%0t got st=%0d lv=%0d ld/run/en/w/l=%b exp st=%0d lv=%0d ld/run/en/w/l=%b",
                 $time, got[W-1 -: 3], got[4 +: LEVEL_BITS], got[4:0],
                 exp[W-1 -: 3], exp[4 +: LEVEL_BITS], exp[4:0]);
      end
      if (timer_load === 1'b1) begin
        checks++;
        if (prev_load === 1'b1) begin
          errors++;
          $display("FAIL load_twice t=%0t got two consecutive timer_load cycles, required one", $time);
        end
      end
      prev_load = timer_load;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic r, input logic s, input logic p,
                     input logic g, input logic t);
    @(negedge clock);
    reset        = r;
    start_btn    = s;
    pause_btn    = p;
    goal_reached = g;
    timer_end    = t;
    @(posedge clock);
    #1;
    model_step(r, s, p, g, t);
    exp_q.push_back(model_outs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with start held across the release: no game may start.
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start, LOAD, PLAY, then three goals ending in WIN and its full hold.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    for (int k = 0; k < NUM_LEVELS; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      if (k < NUM_LEVELS - 1) idle(2);
    end
    idle(RESULT_HOLD + 3);

    // Goal and timeout together go to LEVEL_UP; a later timeout alone loses.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(RESULT_HOLD + 2);

    // Pause at level 1: goal, timeout and start are ignored while paused,
    // resume and pause again, then reset while paused.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Randomized play with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      cyc(logic'($urandom_range(0, 299) != 0),
          logic'($urandom_range(0, 3) == 0),
          logic'($urandom_range(0, 5) == 0),
          logic'($urandom_range(0, 19) == 0),
          logic'($urandom_range(0, 39) == 0));
    end

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
